// File: rtl/apb_master_bridge_if.sv
// CPU-side request/response signals and the shared APB bus of one bridge, grouped.
// The master modport is the bridge's view; the slave modport is the CPU/peripheral side.
interface apb_master_bridge_if #(
    parameter int NUM_SLV = 4
);
    logic                    transfer;
    logic                    write;
    logic [31:0]             addr;
    logic [31:0]             wdata;
    logic [31:0]             rdata;
    logic                    ready;
    logic                    err;
    logic [31:0]             PADDR;
    logic                    PWRITE;
    logic [31:0]             PWDATA;
    logic                    PENABLE;
    logic [NUM_SLV-1:0]      PSEL;
    logic [NUM_SLV*32-1:0]   PRDATA;
    logic [NUM_SLV-1:0]      PREADY;

    modport master (
        input  transfer, write, addr, wdata, PRDATA, PREADY,
        output rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );

    modport slave (
        output transfer, write, addr, wdata, PRDATA, PREADY,
        input  rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 master: turns CPU requests into SETUP/ACCESS transfers,
// decodes the address to a one-hot PSEL and returns PRDATA/PREADY of the selected slave.
module apb_master_bridge #(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    apb_master_bridge_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_ERR
    } state_e;

    state_e       state_q, state_d;
    logic [31:0]  paddr_q, paddr_d;
    logic         pwrite_q, pwrite_d;
    logic [31:0]  pwdata_q, pwdata_d;
    logic [3:0]   sel_q, sel_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         ready_q, ready_d;
    logic         err_q, err_d;

    logic               hit;
    logic [NUM_SLV-1:0] sel_vec;
    logic [31:0]        prdata_sel;
    logic               pready_sel;

    assign hit = (bus.addr[31:16] == BASE_ADDR[31:16]) &&
                 ({1'b0, bus.addr[15:12]} < 5'(NUM_SLV));

    // Only the latched slave's PRDATA/PREADY are visible; the others are ignored.
    always_comb begin
        sel_vec    = '0;
        prdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q == 4'(i)) begin
                sel_vec[i] = 1'b1;
                prdata_sel = bus.PRDATA[32*i +: 32];
            end
        end
    end

    assign pready_sel = |(bus.PREADY & sel_vec);

    // NOTE: every next-state variable gets its default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.transfer) begin
                    if (hit) begin
                        paddr_d  = bus.addr;
                        pwrite_d = bus.write;
                        pwdata_d = bus.wdata;
                        sel_d    = bus.addr[15:12];
                        state_d  = S_SETUP;
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (pready_sel) begin
                    if (!pwrite_q) begin
                        rdata_d = prdata_sel;
                    end
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_d == 8'(TIMEOUT)) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: asynchronous active-low reset; state registers use non-blocking assignments only.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= S_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PENABLE = (state_q == S_ACCESS);
    assign bus.PSEL    = (state_q == S_SETUP || state_q == S_ACCESS) ? sel_vec : '0;
    assign bus.rdata   = rdata_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: behavioural APB slaves with per-slave wait states,
// cycle numbering relative to the edge that samples transfer (T0).
module tb_apb_master_bridge;

    localparam int NUM_SLV = 4;
    localparam int NEVER   = 1000;

    logic PCLK;
    logic PRESETn;

    apb_master_bridge_if #(.NUM_SLV(NUM_SLV)) bus ();

    apb_master_bridge #(
        .NUM_SLV  (NUM_SLV),
        .BASE_ADDR(32'h1000_0000),
        .TIMEOUT  (8)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave model: slave i raises PREADY once it has spent wait_cfg[i] cycles in ACCESS.
    int          wait_cfg [NUM_SLV];
    logic [31:0] prdata_cfg [NUM_SLV];
    int          acc_cnt;
    logic        noise;

    always @(posedge PCLK) begin
        if (bus.PSEL != '0 && bus.PENABLE) acc_cnt <= acc_cnt + 1;
        else                               acc_cnt <= 0;
    end

    always_comb begin
        bus.PREADY = '0;
        bus.PRDATA = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            bus.PRDATA[32*i +: 32] = prdata_cfg[i];
            if (bus.PSEL[i]) bus.PREADY[i] = bus.PENABLE && (acc_cnt >= wait_cfg[i]);
            else             bus.PREADY[i] = noise;
        end
    end

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Presents a request, lets the T0 edge sample it, returns in cycle T1 with transfer low.
    task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.transfer = 1'b1;
        bus.write    = w;
        bus.addr     = a;
        bus.wdata    = d;
        step();
        bus.transfer = 1'b0;
    endtask

    // Steps until ready (bounded); lat is the T-index of the ready cycle.
    task automatic wait_done(output int lat, output int acc, output logic [NUM_SLV-1:0] psel_seen);
        lat       = 1;
        acc       = 0;
        psel_seen = '0;
        while (!bus.ready && lat < 40) begin
            psel_seen |= bus.PSEL;
            if (bus.PENABLE) acc++;
            step();
            lat++;
        end
    endtask

    int                 lat;
    int                 acc;
    logic [NUM_SLV-1:0] psel_seen;
    int                 r1;
    int                 r2;
    logic [NUM_SLV-1:0] psel_gap;
    logic [31:0]        rdata2;
    logic               err1;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        noise   = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            wait_cfg[i]   = 0;
            prdata_cfg[i] = 32'hD0D0_0000 + i;
        end
        prdata_cfg[1] = 32'h0000_CAFE;
        wait_cfg[1]   = 2;
        prdata_cfg[2] = 32'h5A5A_0002;
        wait_cfg[2]   = 1;
        bus.transfer  = 1'b0;
        bus.write     = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        PRESETn       = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_psel",    32'(bus.PSEL),    32'h0);
        check("rst_penable", 32'(bus.PENABLE), 32'h0);
        check("rst_ready",   32'(bus.ready),   32'h0);
        check("rst_paddr",   bus.PADDR,        32'h0);
        check("rst_rdata",   bus.rdata,        32'h0);
        PRESETn = 1'b1;
        step();

        // 1: zero-wait write to slave0
        start(1'b1, 32'h1000_0004, 32'h0000_1234);
        check("t1_psel_T1",    32'(bus.PSEL),    32'h1);
        check("t1_penable_T1", 32'(bus.PENABLE), 32'h0);
        step();
        check("t1_penable_T2", 32'(bus.PENABLE), 32'h1);
        check("t1_pwdata",     bus.PWDATA,       32'h0000_1234);
        check("t1_paddr",      bus.PADDR,        32'h1000_0004);
        check("t1_pwrite",     32'(bus.PWRITE),  32'h1);
        check("t1_ready_T2",   32'(bus.ready),   32'h0);
        step();
        check("t1_ready_T3",   32'(bus.ready),   32'h1);
        check("t1_err_T3",     32'(bus.err),     32'h0);
        check("t1_psel_T3",    32'(bus.PSEL),    32'h0);
        step();
        check("t1_ready_pulse", 32'(bus.ready),  32'h0);

        // 2: read from slave1 with 2 wait states
        start(1'b0, 32'h1000_1000, 32'h0);
        wait_done(lat, acc, psel_seen);
        check("t2_latency", 32'(lat),       32'd5);
        check("t2_access",  32'(acc),       32'd3);
        check("t2_psel",    32'(psel_seen), 32'h2);
        check("t2_rdata",   bus.rdata,      32'h0000_CAFE);
        check("t2_err",     32'(bus.err),   32'h0);
        step();

        // 3: decode misses (outside region, and slave index beyond NUM_SLV)
        start(1'b0, 32'h2000_0000, 32'h0);
        check("t3a_psel",  32'(bus.PSEL),  32'h0);
        check("t3a_ready", 32'(bus.ready), 32'h1);
        check("t3a_err",   32'(bus.err),   32'h1);
        step();
        check("t3a_ready_pulse", 32'(bus.ready), 32'h0);
        start(1'b1, 32'h1000_4000, 32'h0);
        check("t3b_psel",  32'(bus.PSEL),  32'h0);
        check("t3b_ready", 32'(bus.ready), 32'h1);
        check("t3b_err",   32'(bus.err),   32'h1);
        step();

        // 4: timeout on slave0 while every other slave holds PREADY high
        wait_cfg[0] = NEVER;
        noise       = 1'b1;
        start(1'b0, 32'h1000_0000, 32'h0);
        wait_done(lat, acc, psel_seen);
        check("t4_access",  32'(acc),       32'd8);
        check("t4_latency", 32'(lat),       32'd10);
        check("t4_ready",   32'(bus.ready), 32'h1);
        check("t4_err",     32'(bus.err),   32'h1);
        check("t4_psel",    32'(bus.PSEL),  32'h0);
        check("t4_rdata",   bus.rdata,      32'h0000_CAFE);
        step();
        wait_cfg[0] = 0;
        noise       = 1'b0;
        start(1'b1, 32'h1000_0008, 32'h0000_00AA);
        wait_done(lat, acc, psel_seen);
        check("t4_next_latency", 32'(lat),     32'd3);
        check("t4_next_err",     32'(bus.err), 32'h0);
        step();

        // 5: reset while slave3 stalls in ACCESS
        wait_cfg[3] = NEVER;
        start(1'b0, 32'h1000_3000, 32'h0);
        step();
        check("t5_in_access", 32'(bus.PENABLE), 32'h1);
        PRESETn = 1'b0;
        #1;
        check("t5_psel",    32'(bus.PSEL),    32'h0);
        check("t5_penable", 32'(bus.PENABLE), 32'h0);
        check("t5_ready",   32'(bus.ready),   32'h0);
        check("t5_rdata",   bus.rdata,        32'h0);
        step();
        PRESETn = 1'b1;
        step();
        check("t5_no_ready", 32'(bus.ready), 32'h0);
        start(1'b1, 32'h1000_0010, 32'h0000_0055);
        wait_done(lat, acc, psel_seen);
        check("t5_after_latency", 32'(lat),       32'd3);
        check("t5_after_err",     32'(bus.err),   32'h0);
        check("t5_after_psel",    32'(psel_seen), 32'h1);
        step();

        // 6: transfer held high: write then read to slave2 (PREADY one cycle into ACCESS)
        r1       = -1;
        r2       = -1;
        psel_gap = '1;
        rdata2   = '0;
        err1     = 1'b1;
        bus.transfer = 1'b1;
        bus.write    = 1'b1;
        bus.addr     = 32'h1000_2008;
        bus.wdata    = 32'h0000_BEEF;
        for (int k = 1; k <= 20 && r2 < 0; k++) begin
            step();
            if (bus.ready) begin
                if (r1 < 0) begin
                    r1        = k;
                    psel_gap  = bus.PSEL;
                    err1      = bus.err;
                    bus.write = 1'b0;
                    bus.addr  = 32'h1000_2010;
                end else begin
                    r2           = k;
                    rdata2       = bus.rdata;
                    bus.transfer = 1'b0;
                end
            end
        end
        check("t6_first_ready",  32'(r1),       32'd4);
        check("t6_spacing",      32'(r2 - r1),  32'd4);
        check("t6_psel_gap",     32'(psel_gap), 32'h0);
        check("t6_write_err",    32'(err1),     32'h0);
        check("t6_read_rdata",   rdata2,        32'h5A5A_0002);
        step();
        check("t6_idle_after",   32'(bus.PSEL), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
